harq_send_reader: RTL
=====================

// Module: harq_send_reader
// PURPOSE
//  Drains one completed 160-bit combine buffer (16 x 10-bit signed soft values per word) out of the
//  COMB ping/pong SRAM pair and streams it to the HARQ store path with valid/ready backpressure.
//  Drives the SENDHARQ read side of the combine FSM: owns the read address, returns Data_Comp when
//  the buffer is fully drained. Output values are saturated to OUT_W bits.
// PARAMETERS
//  ADDR_W   11  SRAM word address width
//  NUM_LLR  16  soft values per SRAM word
//  IN_W     10  signed width of each stored soft value
//  OUT_W    8   signed width of each output soft value
// PORTS
//  i_core_clk                          in   1    core clock
//  i_rx_rstn                           in   1    asynchronous, active-low reset
//  i_rx_fsm_rstn                       in   1    asynchronous, active-low FSM reset (same effect as i_rx_rstn)
//  i_SENDHARQ_Data_request             in   1    start drain; sampled in IDLE only
//  i_SENDHARQ_Data_PingPong_Indicator  in   1    1 = drain Ping buffer, 0 = drain Pong; captured with request
//  i_SENDHARQ_Data_ncb                 in   16   Ncb of the user; word count = ncb[15:4]+1
//  o_SENDHARQ_Data_Comp                out  1    1-cycle pulse: buffer fully drained and released
//  o_SENDHARQ_Data_Address             out  11   registered SRAM read address
//  i_ping_rd_data                      in   160  Ping SRAM q (1-cycle registered read)
//  i_pong_rd_data                      in   160  Pong SRAM q (1-cycle registered read)
//  o_harq_valid                        out  1    output word valid
//  i_harq_ready                        in   1    downstream accepts word when valid&ready
//  o_harq_data                         out  128  NUM_LLR x OUT_W saturated values, value k at [k*8+7:k*8]
//  o_harq_last                         out  1    marks final word of the buffer (with o_harq_valid)
// BEHAVIOUR
//  Reset (either reset low): state IDLE; all outputs 0; skid FIFO empty; captured ncb/indicator 0.
//  Word count N = min(ncb[15:4],2047)+1; addresses 0..N-1 read in ascending order, each exactly once.
//  SRAM timing: address held in cycle t -> data valid on selected q in cycle t+1; captured then.
//  States: IDLE -> READ (request=1; capture indicator, N; address=0)
//    READ: issue address when credit available; advance address by 1 per issue.
//          After issuing address N-1 -> DRAIN.
//    DRAIN: wait until in-flight read landed and skid FIFO empty with last word accepted -> DONE.
//    DONE: o_SENDHARQ_Data_Comp=1 for exactly this cycle -> IDLE; address returns to 0.
//  Flow control: 2-entry skid FIFO after the saturation stage. Issue allowed only when
//    fifo_count + reads_in_flight < 2; no word is ever dropped or duplicated under any ready pattern.
//  Throughput: with i_harq_ready held 1, one word per cycle; first o_harq_valid 2 cycles after READ entry.
//  Saturation per value (signed IN_W -> OUT_W): clamp to [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)],
//    i.e. +-127 for OUT_W=8; symmetric, -128 never produced. In-range values pass unchanged.
//  Data select uses the captured indicator, not the live input; input changes mid-drain are ignored.
//  o_harq_data/o_harq_last stable while o_harq_valid=1 and i_harq_ready=0.
//  o_harq_last=1 only on word N-1. N=1 (ncb<16): single word with last=1.
//  Request while not IDLE: ignored. Request in DONE cycle: ignored (re-sampled next cycle in IDLE).
//  Reset mid-drain: immediate return to IDLE, FIFO flushed, no Comp pulse, valid drops to 0.
// TESTING
//  T1 ncb=16'd160, ping=1, ready=1, Ping word a = {16{10'(a)}} -> 11 words, addr 0..10, data k = sat(a),
//     last on word 10, Comp one cycle after last accept.
//  T2 values 10'sd511,-512,127,-127,-128,128,0,-1 -> outputs 127,-127,127,-127,-127,127,0,-1.
//  T3 ncb=16'd4000 (N=251), random ready ~50% -> 251 words in order, none lost/duplicated, data stable
//     while stalled, FIFO never >2 entries.
//  T4 pong drain (indicator=0) with ping q carrying garbage -> only pong data appears; indicator toggled
//     mid-drain has no effect.
//  T5 ncb=16'd8, ready=0 for 20 cycles then 1 -> exactly 1 word, last=1, Comp after acceptance.
//  T6 assert i_rx_fsm_rstn low at word 5 of 50 -> valid=0, address=0, no Comp; new request restarts at addr 0.

Source files
------------

// File: rtl/harq_send_reader.sv
// harq_send_reader: drains one combine buffer from the COMB ping/pong SRAM pair.
// Each 160-bit word holds 16 signed 10-bit soft values. Every value is saturated
// to a symmetric 8-bit range, and the word is then streamed to the HARQ store
// path through a 2-entry skid FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_SENDHARQ_Data_request
// READ  | issuing addresses 0..N-1 whenever FIFO credit allows
// DRAIN | last address issued; waiting for the read to land and the FIFO to empty
// DONE  | one-cycle o_SENDHARQ_Data_Comp pulse, then back to IDLE
module harq_send_reader #(
  parameter int ADDR_W  = 11,
  parameter int NUM_LLR = 16,
  parameter int IN_W    = 10,
  parameter int OUT_W   = 8
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rstn,
  input  logic                      i_rx_fsm_rstn,
  input  logic                      i_SENDHARQ_Data_request,
  input  logic                      i_SENDHARQ_Data_PingPong_Indicator,
  input  logic [15:0]               i_SENDHARQ_Data_ncb,
  output logic                      o_SENDHARQ_Data_Comp,
  output logic [ADDR_W-1:0]         o_SENDHARQ_Data_Address,
  input  logic [NUM_LLR*IN_W-1:0]   i_ping_rd_data,
  input  logic [NUM_LLR*IN_W-1:0]   i_pong_rd_data,
  output logic                      o_harq_valid,
  input  logic                      i_harq_ready,
  output logic [NUM_LLR*OUT_W-1:0]  o_harq_data,
  output logic                      o_harq_last
);

  localparam int WORDS_MAX = (2 ** ADDR_W) - 1;
  localparam int SAT_MAX   = (2 ** (OUT_W - 1)) - 1;
  localparam logic signed [IN_W-1:0]  C_IN_HI  = IN_W'(SAT_MAX);
  localparam logic signed [IN_W-1:0]  C_IN_LO  = IN_W'(-SAT_MAX);
  localparam logic signed [OUT_W-1:0] C_OUT_HI = OUT_W'(SAT_MAX);
  localparam logic signed [OUT_W-1:0] C_OUT_LO = OUT_W'(-SAT_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Either reset returns the whole block to its idle state.
  logic w_rst_n;
  assign w_rst_n = i_rx_rstn & i_rx_fsm_rstn;

  state_t                    r_state, w_state_nxt;
  logic [15:0]               r_ncb;
  logic                      r_ind;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_inflight;
  logic                      r_inflight_last;
  logic [NUM_LLR*OUT_W-1:0]  r_fifo_data [2];
  logic                      r_fifo_last [2];
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;

  logic [15:0]               w_ncb_words;
  logic [ADDR_W-1:0]         w_last_addr;
  logic                      w_at_last;
  logic                      w_pop;
  logic                      w_push;
  logic [2:0]                w_occ;
  logic                      w_issue;
  logic [NUM_LLR*IN_W-1:0]   w_rd_word;
  logic signed [IN_W-1:0]    w_llr [NUM_LLR];
  logic [NUM_LLR*OUT_W-1:0]  w_sat;

  // Last address of the buffer, clamped to the SRAM depth.
  always_comb begin
    w_ncb_words = r_ncb >> 4;
    if (w_ncb_words > 16'(WORDS_MAX)) begin
      w_last_addr = ADDR_W'(WORDS_MAX);
    end else begin
      w_last_addr = w_ncb_words[ADDR_W-1:0];
    end
  end

  assign w_at_last = (r_addr == w_last_addr);
  assign w_pop     = (r_count != 2'd0) && i_harq_ready;
  assign w_push    = r_inflight;

  // Credit counts the entry leaving this cycle, which keeps one word per cycle
  // flowing with ready high while never letting more than two words be owed.
  always_comb begin
    w_occ   = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
    w_issue = (r_state == S_READ) && (w_occ < 3'd2);
  end

  // Select the captured buffer and clamp each value symmetrically.
  always_comb begin
    w_rd_word = r_ind ? i_ping_rd_data : i_pong_rd_data;
    w_sat     = '0;
    for (int k = 0; k < NUM_LLR; k++) begin
      w_llr[k] = w_rd_word[k*IN_W +: IN_W];
      if (w_llr[k] > C_IN_HI) begin
        w_sat[k*OUT_W +: OUT_W] = C_OUT_HI;
      end else if (w_llr[k] < C_IN_LO) begin
        w_sat[k*OUT_W +: OUT_W] = C_OUT_LO;
      end else begin
        w_sat[k*OUT_W +: OUT_W] = w_llr[k][OUT_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_core_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_SENDHARQ_Data_request) w_state_nxt = S_READ;
      S_READ:  if (w_issue && w_at_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_inflight &&
                   ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
                 w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_SENDHARQ_Data_Comp    = (r_state == S_DONE);
    o_SENDHARQ_Data_Address = r_addr;
  end

  // Capture buffer select and Ncb when a drain starts.
  always_ff @(posedge i_core_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ncb <= '0;
      r_ind <= 1'b0;
    end else if ((r_state == S_IDLE) && i_SENDHARQ_Data_request) begin
      r_ncb <= i_SENDHARQ_Data_ncb;
      r_ind <= i_SENDHARQ_Data_PingPong_Indicator;
    end
  end

  // Read address: advances per issue, holds on the last word, clears in DONE.
  always_ff @(posedge i_core_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_addr <= '0;
    end else if (r_state == S_DONE) begin
      r_addr <= '0;
    end else if (w_issue && !w_at_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Track the single outstanding SRAM read and whether it is the final word.
  always_ff @(posedge i_core_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_at_last;
    end
  end

  // Skid FIFO: two entries, the occupancy bound is guaranteed by the issue credit.
  always_ff @(posedge i_core_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_sat;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_harq_valid = (r_count != 2'd0);
  assign o_harq_data  = r_fifo_data[r_rd_ptr];
  assign o_harq_last  = o_harq_valid && r_fifo_last[r_rd_ptr];

endmodule
